// File: rtl/lut_ram_bist.sv
// March BIST for a lut_ram: writes base(a) then ~base(a), verifying
// each pass with an async read and recording the first failure.
module lut_ram_bist #(
  parameter int LUT_WIDTH = 32,
  parameter int LUT_DEPTH = 256,
  localparam int AW = $clog2(LUT_DEPTH),
  localparam int CW = $clog2(2*LUT_DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 ram_wr_en,
  output logic [AW-1:0]        ram_wr_addr,
  output logic [LUT_WIDTH-1:0] ram_wr_data,
  output logic [AW-1:0]        ram_rd_addr,
  input  logic [LUT_WIDTH-1:0] ram_rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CW-1:0]        err_count,
  output logic [AW-1:0]        fail_addr,
  output logic                 fail_pass
);

  typedef enum logic [1:0] {
    IDLE, WR, RD, DONE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(LUT_DEPTH-1);

  state_t          state, state_n;
  logic [AW-1:0]   cnt, cnt_n;
  logic            pidx, pidx_n;
  logic [CW-1:0]   err_q, err_n;
  logic [AW-1:0]   fa_q, fa_n;
  logic            fp_q, fp_n;
  logic [LUT_WIDTH-1:0] base, pat;
  logic            last, mism;

  always_comb begin
    base = LUT_WIDTH'(cnt);
    pat  = pidx ? ~base : base;
    last = (cnt == LAST);
    mism = (state == RD) && (ram_rd_data != pat);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pidx_n  = pidx;
    err_n   = err_q;
    fa_n    = fa_q;
    fp_n    = fp_q;
    unique case (state)
      IDLE, DONE: begin
        // abort outranks a coincident start
        if (start && !abort) begin
          state_n = WR;
          cnt_n   = '0;
          pidx_n  = 1'b0;
          err_n   = '0;
          fa_n    = '0;
          fp_n    = 1'b0;
        end
      end
      WR: begin
        cnt_n = cnt + 1'b1;
        if (last) state_n = RD;
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
          pidx_n  = 1'b0;
        end
      end
      RD: begin
        if (mism) begin
          err_n = err_q + 1'b1;
          if (err_q == '0) begin
            fa_n = cnt;
            fp_n = pidx;
          end
        end
        cnt_n = cnt + 1'b1;
        if (last) begin
          state_n = pidx ? DONE : WR;
          pidx_n  = 1'b1;
        end
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
          pidx_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pidx  <= 1'b0;
      err_q <= '0;
      fa_q  <= '0;
      fp_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pidx  <= pidx_n;
      err_q <= err_n;
      fa_q  <= fa_n;
      fp_q  <= fp_n;
    end
  end

  // decoded from state so reset drops them without a clock edge
  assign ram_wr_en   = (state == WR);
  assign ram_wr_addr = (state == WR) ? cnt : '0;
  assign ram_wr_data = (state == WR) ? pat : '0;
  assign ram_rd_addr = (state == RD) ? cnt : '0;
  assign busy        = (state == WR) || (state == RD);
  assign done        = (state == DONE);
  assign pass        = done && (err_q == '0);
  assign err_count   = err_q;
  assign fail_addr   = fa_q;
  assign fail_pass   = fp_q;

endmodule

// File: tb/tb_lut_ram_bist.sv
// Bench for lut_ram_bist on a 16x8 RAM model with injectable faults,
// checked against a behavioural march model.
module tb_lut_ram_bist;

  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst_n, start, abort;
  logic         ram_wr_en;
  logic [3:0]   ram_wr_addr, ram_rd_addr;
  logic [W-1:0] ram_wr_data, ram_rd_data;
  logic         busy, done, pass;
  logic [5:0]   err_count;
  logic [3:0]   fail_addr;
  logic         fail_pass;

  int n_cmp = 0;
  int n_bad = 0;

  // fault mode: 0 good, 1 rd bit0 stuck-0, 2 addr bit3 ignored, 3 xor at one addr
  int           mode = 0;
  int           fa = 0;
  logic [W-1:0] xm = 8'h00;
  logic [W-1:0] mem [D];
  logic [W-1:0] wq [$];

  lut_ram_bist #(.LUT_WIDTH(W), .LUT_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_addr(fail_addr),
    .fail_pass(fail_pass)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_wr_en)
      mem[(mode == 2) ? {1'b0, ram_wr_addr[2:0]} : ram_wr_addr] <= ram_wr_data;

  always_comb begin
    ram_rd_data = mem[(mode == 2) ? {1'b0, ram_rd_addr[2:0]} : ram_rd_addr];
    if (mode == 1) ram_rd_data[0] = 1'b0;
    if (mode == 3 && int'(ram_rd_addr) == fa) ram_rd_data = ram_rd_data ^ xm;
  end

  function automatic void model(output int e, output int f_a, output int f_p);
    logic [W-1:0] m [D];
    logic [W-1:0] pt, rd;
    int idx;
    e = 0; f_a = 0; f_p = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < D; a++) begin
        idx = (mode == 2) ? a % 8 : a;
        m[idx] = p ? ~8'(a) : 8'(a);
      end
      for (int a = 0; a < D; a++) begin
        pt = p ? ~8'(a) : 8'(a);
        rd = m[(mode == 2) ? a % 8 : a];
        if (mode == 1) rd[0] = 1'b0;
        if (mode == 3 && a == fa) rd = rd ^ xm;
        if (rd != pt) begin
          if (e == 0) begin f_a = a; f_p = p; end
          e++;
        end
      end
    end
  endfunction

  // pulse start (edge 0), then observe cycle k at the negedge before edge k
  task automatic run(input int abort_at, input int start_at, input int maxc,
                     output int done_at, output int busy_n, output int err1);
    wq.delete();
    busy_n = 0; done_at = -1; err1 = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= maxc; k++) begin
      if (k == abort_at) abort = 1'b1;
      if (k == start_at) start = 1'b1;
      @(negedge clk);
      if (k == 1) err1 = int'(err_count);
      if (busy) busy_n++;
      if (ram_wr_en) wq.push_back(ram_wr_data);
      if (done) begin done_at = k; break; end
      @(posedge clk); #1 abort = 1'b0; start = 1'b0;
    end
    abort = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({ram_wr_en, busy, done, pass, fail_pass} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags got %b want 00000",
                        {ram_wr_en, busy, done, pass, fail_pass}); end
    n_cmp++; if ({ram_wr_addr, ram_rd_addr, ram_wr_data} !== 16'h0) begin
      n_bad++; $display("FAIL reset_ram_bus got %h want 0000",
                        {ram_wr_addr, ram_rd_addr, ram_wr_data}); end
    n_cmp++; if ({err_count, fail_addr} !== 10'h0) begin
      n_bad++; $display("FAIL reset_results got %h want 000",
                        {err_count, fail_addr}); end
    rst_n = 1'b1;
  endtask

  task automatic test_good;
    int da, bn, e1;
    logic [W-1:0] exp_w;
    mode = 0;
    run(0, 0, 100, da, bn, e1);
    n_cmp++; if (da !== 65) begin
      n_bad++; $display("FAIL good_done_cycle got %0d want 65", da); end
    n_cmp++; if (bn !== 64) begin
      n_bad++; $display("FAIL good_busy_cycles got %0d want 64", bn); end
    n_cmp++; if (wq.size() !== 32) begin
      n_bad++; $display("FAIL good_wr_count got %0d want 32", wq.size()); end
    for (int i = 0; i < 32 && i < wq.size(); i++) begin
      exp_w = (i < 16) ? 8'(i) : ~8'(i - 16);
      n_cmp++; if (wq[i] !== exp_w) begin
        n_bad++; $display("FAIL good_wr_data[%0d] got %h want %h", i, wq[i], exp_w); end
    end
    n_cmp++; if ({pass, err_count} !== {1'b1, 6'd0}) begin
      n_bad++; $display("FAIL good_result got pass=%b err=%0d want pass=1 err=0",
                        pass, err_count); end
  endtask

  task automatic test_fault(input int md, input string nm);
    int da, bn, e1, ee, efa, efp;
    mode = md;
    run(0, 0, 100, da, bn, e1);
    model(ee, efa, efp);
    n_cmp++; if (da !== 65) begin
      n_bad++; $display("FAIL %s_done_cycle got %0d want 65", nm, da); end
    n_cmp++; if (int'(err_count) !== ee || pass !== (ee == 0)) begin
      n_bad++; $display("FAIL %s_err got err=%0d pass=%b want err=%0d pass=%b",
                        nm, err_count, pass, ee, ee == 0); end
    n_cmp++; if (int'(fail_addr) !== efa || int'(fail_pass) !== efp) begin
      n_bad++; $display("FAIL %s_first got addr=%0d pass=%0d want addr=%0d pass=%0d",
                        nm, fail_addr, fail_pass, efa, efp); end
  endtask

  task automatic test_stuck_fixed;
    test_fault(1, "stuck");
    n_cmp++; if ({err_count, fail_addr, fail_pass, pass} !== {6'd16, 4'd1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL stuck_spec got err=%0d fa=%0d fp=%b pass=%b want 16 1 0 0",
                        err_count, fail_addr, fail_pass, pass); end
  endtask

  task automatic test_restart_clears;
    int da, bn, e1;
    mode = 0;
    run(0, 0, 100, da, bn, e1);
    n_cmp++; if (e1 !== 0) begin
      n_bad++; $display("FAIL restart_err_clear got %0d want 0", e1); end
    n_cmp++; if ({pass, da} !== {1'b1, 32'd65}) begin
      n_bad++; $display("FAIL restart_rerun got pass=%b done=%0d want 1 65", pass, da); end
  endtask

  task automatic test_alias_fixed;
    test_fault(2, "alias");
    n_cmp++; if ({err_count, fail_addr, fail_pass} !== {6'd16, 4'd0, 1'b0}) begin
      n_bad++; $display("FAIL alias_spec got err=%0d fa=%0d fp=%b want 16 0 0",
                        err_count, fail_addr, fail_pass); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      fa = $urandom_range(0, D - 1);
      xm = 8'($urandom_range(1, 255));
      test_fault($urandom_range(0, 3), "random");
    end
    mode = 0;
  endtask

  task automatic test_start_while_busy;
    int da, bn, e1;
    mode = 0;
    run(0, 10, 100, da, bn, e1);
    n_cmp++; if ({da, bn} !== {32'd65, 32'd64}) begin
      n_bad++; $display("FAIL busy_start got done=%0d busy=%0d want 65 64", da, bn); end
  endtask

  task automatic test_abort;
    int da, bn, e1;
    mode = 0;
    run(20, 0, 22, da, bn, e1);
    n_cmp++; if (bn !== 20) begin
      n_bad++; $display("FAIL abort_busy_cycles got %0d want 20", bn); end
    n_cmp++; if ({busy, ram_wr_en, done} !== 3'b000) begin
      n_bad++; $display("FAIL abort_idle got %b want 000", {busy, ram_wr_en, done}); end
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_beats_start got busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset;
    int da, bn, e1;
    mode = 0;
    run(0, 0, 40, da, bn, e1);
    n_cmp++; if ({busy, ram_wr_en} !== 2'b11) begin
      n_bad++; $display("FAIL rst_pre got %b want 11", {busy, ram_wr_en}); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, ram_wr_en, ram_wr_data} !== 10'h0) begin
      n_bad++; $display("FAIL rst_async got %h want 000", {busy, ram_wr_en, ram_wr_data}); end
    @(negedge clk); rst_n = 1'b1;
    run(0, 0, 100, da, bn, e1);
    n_cmp++; if ({pass, da, bn} !== {1'b1, 32'd65, 32'd64}) begin
      n_bad++; $display("FAIL rst_rerun got pass=%b done=%0d busy=%0d want 1 65 64",
                        pass, da, bn); end
  endtask

  initial begin
    test_reset;
    test_good;
    test_stuck_fixed;
    test_restart_clears;
    test_alias_fixed;
    test_random;
    test_start_while_busy;
    test_abort;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lut_ram_bist.md
Name: lut_ram_bist

Overview:
- Built-in self-test controller that acts as the initiator for a lut_ram instance. It drives the write port and read address, and checks the asynchronous read data.
- Runs a two-pass write/read-verify march across every address and reports pass/fail, the error count and the first failing location.
- Sits beside any lut_ram-based storage (register file, data LUTs). It is muxed onto the RAM ports by the integrator while busy is high.

Parameters:
- LUT_WIDTH, 32, data width of the RAM under test.
- LUT_DEPTH, 256, number of RAM entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a test; sampled at posedge.
- abort  input  1  synchronous abort; returns the block to IDLE.
- ram_wr_en  output  1  RAM write enable.
- ram_wr_addr  output  $clog2(LUT_DEPTH)  RAM write address.
- ram_wr_data  output  LUT_WIDTH  RAM write data.
- ram_rd_addr  output  $clog2(LUT_DEPTH)  RAM read address.
- ram_rd_data  input  LUT_WIDTH  asynchronous RAM read data, valid in the same cycle as ram_rd_addr.
- busy  output  1  high in WR or RD states.
- done  output  1  test complete; held until the next start.
- pass  output  1  valid when done is high; 1 means err_count == 0.
- err_count  output  $clog2(2*LUT_DEPTH+1)  number of mismatching reads in the run.
- fail_addr  output  $clog2(LUT_DEPTH)  address of the first mismatch.
- fail_pass  output  1  pass index (0 or 1) of the first mismatch.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, addr counter=0, pass index=0.
  - All outputs are 0: ram_wr_en, addrs, wr_data, busy, done, pass, err_count, fail_addr, fail_pass.
  - ram_wr_en falls immediately, without waiting for a clock edge.
- Pattern: base(a) = a zero-extended (or truncated) to LUT_WIDTH.
  - Pass 0 writes base(a).
  - Pass 1 writes ~base(a).
- States: IDLE -> WR -> RD -> (pass 0: WR with pass index=1 | pass 1: DONE).
- IDLE / DONE:
  - start=1 -> WR, with counter=0, pass index=0.
  - Also clears err_count, fail_addr, fail_pass, done and pass.
- WR:
  - ram_wr_en=1, ram_wr_addr=counter, ram_wr_data=pattern.
  - Exactly LUT_DEPTH cycles, addresses 0..LUT_DEPTH-1 ascending.
  - On the last address, the counter wraps to 0 and the state moves to RD.
- RD:
  - ram_wr_en=0, ram_rd_addr=counter.
  - ram_rd_data is compared combinationally against the pattern for the current pass.
  - On a mismatch, err_count increments at the posedge.
  - If this is the first mismatch of the run (err_count==0), fail_addr and fail_pass are captured.
  - Exactly LUT_DEPTH cycles; wraps as in WR.
- Outputs outside WR: ram_wr_en=0 in every state other than WR. ram_wr_addr, ram_wr_data and ram_rd_addr hold 0 in IDLE and DONE.
- DONE:
  - done=1 and pass=(err_count==0).
  - Results are held until start or reset.
- Latency:
  - start is sampled at edge 0.
  - WR cycles 1..D, RD cycles D+1..2D, WR cycles 2D+1..3D, RD cycles 3D+1..4D.
  - done rises after edge 4D. Total 4*LUT_DEPTH busy cycles.
- start while busy: ignored.
- abort while busy:
  - Next state is IDLE; busy=0, done=0 and ram_wr_en=0 after that edge.
  - err_count, fail_addr and fail_pass keep their partial values.
- abort and start in the same cycle: abort wins.
- abort in IDLE/DONE: no effect.
- err_count cannot overflow: its maximum value is 2*LUT_DEPTH.

Test Plan:
- Good RAM (lut_ram, WIDTH=8, DEPTH=16), pulse start:
  - busy high for 64 cycles; 32 write cycles with wr_data 0x00..0x0F then 0xFF..0xF0.
  - done after edge 64, pass=1, err_count=0.
- Stuck-at-0 on rd_data[0]:
  - Pass 0 fails at odd addresses, pass 1 at even addresses.
  - err_count=16, fail_addr=1, fail_pass=0, pass=0.
- Address alias (RAM ignores addr bit 3):
  - Each pass reads 8..15 back at addresses 0..7 (and the inverted values in pass 1).
  - err_count=16, fail_addr=0, fail_pass=0.
- start pulsed again at cycle 10 while busy:
  - Ignored; done still at edge 64.
- abort at cycle 20 (in RD, pass 0):
  - IDLE next cycle; busy=0, ram_wr_en=0, done=0.
- rst_n low mid pass-1 WR:
  - ram_wr_en and busy drop with no clock edge.
  - After release, start reruns cleanly.
- Restart from DONE after the failing run:
  - err_count clears to 0 on the start edge.
